// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            data access. Data has priority. Optional IF anti-starvation guard
//            is enabled by defining MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_done,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_stall,
  output logic              o_busy
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BUSY_I = 2'd1;
  localparam logic [1:0] c_BUSY_D = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  localparam int                  c_STREAK_W   = $clog2(MAX_DSTREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DSTREAK);

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  r_is_d;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_dm_rdata;
  logic [c_STREAK_W-1:0] r_streak;
  logic                  w_idle;
  logic                  w_force_if;
  logic                  w_grant_d;
  logic                  w_grant_i;

  assign w_idle = (r_state == c_IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  assign w_force_if = i_if_req && (r_streak == c_STREAK_MAX);
`else
  assign w_force_if = 1'b0;
`endif

  assign w_grant_d = w_idle & i_dm_req & ~w_force_if;
  assign w_grant_i = w_idle & i_if_req & ~w_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_d)      w_next = c_BUSY_D;
        else if (w_grant_i) w_next = c_BUSY_I;
      end
      c_BUSY_I, c_BUSY_D: begin
        if (i_mem_ack) w_next = c_RESP;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req = 1'b0;
    o_if_done = 1'b0;
    o_dm_done = 1'b0;
    o_busy    = 1'b1;
    case (r_state)
      c_IDLE:             o_busy    = 1'b0;
      c_BUSY_I, c_BUSY_D: o_mem_req = 1'b1;
      default: begin
        o_if_done = ~r_is_d;
        o_dm_done = r_is_d;
      end
    endcase
  end

  // Request copies are latched at grant so requester changes mid-access are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_d      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_grant_d) begin
        r_is_d      <= 1'b1;
        r_mem_we    <= i_dm_we;
        r_mem_addr  <= i_dm_addr;
        r_mem_wdata <= i_dm_wdata;
      end else if (w_grant_i) begin
        r_is_d     <= 1'b0;
        r_mem_we   <= 1'b0;
        r_mem_addr <= i_if_addr;
      end
      if (i_mem_ack && (r_state == c_BUSY_I))
        r_if_rdata <= i_mem_rdata;
      if (i_mem_ack && (r_state == c_BUSY_D) && !r_mem_we)
        r_dm_rdata <= i_mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (w_grant_i) begin
      r_streak <= '0;
    end else if (w_grant_d) begin
      if (!i_if_req)                    r_streak <= '0;
      else if (r_streak != c_STREAK_MAX) r_streak <= r_streak + 1'b1;
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_stall     = (i_if_req & ~o_if_done) | (i_dm_req & ~o_dm_done);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (directed table,
//            multi-cycle corner sequences, randomized traffic vs. model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MAXS = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, mem_req, mem_we, stall, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_done(if_done),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_rdata(dm_rdata), .o_dm_done(dm_done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_stall(stall), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory behind the arbiter, plus a log of every completed access.
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  logic [31:0] mem [logic [31:0]];
  acc_t        acc_q[$];
  bit          auto_ack = 1'b1;
  bit          rnd_mode = 1'b0;
  bit          pulse_ack = 1'b0;
  int          lat = 1;
  int          cnt = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Transaction-level reference: who owns the memory and what it must show.
  int          m_phase;   // 0 free, 1 access in flight, 2 reply cycle
  bit          m_d;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  int          m_streak;

  task automatic model_step();
    bit starve;
    if (!rst_n) begin
      m_phase = 0; m_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_if_rdata = 0; m_dm_rdata = 0; m_streak = 0;
      return;
    end
    if (m_phase == 0) begin
      starve = GUARD && if_req && (m_streak == MAXS);
      if (dm_req && !starve) begin
        m_phase = 1; m_d = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (if_req) begin
        m_phase = 1; m_d = 0; m_we = 0; m_addr = if_addr; m_streak = 0;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_phase = 2;
        if (!m_d)      m_if_rdata = mem_rdata;
        else if (!m_we) m_dm_rdata = mem_rdata;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    logic e_if_done, e_dm_done;
    e_if_done = (m_phase == 2) && !m_d;
    e_dm_done = (m_phase == 2) && m_d;
    chk("mdl_mem_req",  mem_req,  m_phase == 1);
    chk("mdl_busy",     busy,     m_phase != 0);
    chk("mdl_if_done",  if_done,  e_if_done);
    chk("mdl_dm_done",  dm_done,  e_dm_done);
    chk("mdl_stall",    stall,    (if_req & ~e_if_done) | (dm_req & ~e_dm_done));
    chk("mdl_if_rdata", if_rdata, m_if_rdata);
    chk("mdl_dm_rdata", dm_rdata, m_dm_rdata);
    if (m_phase == 1) begin
      chk("mdl_mem_addr", mem_addr, m_addr);
      chk("mdl_mem_we",   mem_we,   m_we);
      if (m_we) chk("mdl_mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (pulse_ack) begin
      mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE; pulse_ack = 1'b0;
    end else if (auto_ack && mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_word(mem_addr);
        acc_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
        cnt = 0;
        if (rnd_mode) lat = $urandom_range(1, 3);
      end
    end else begin
      cnt = 0;
      if (rnd_mode && $urandom_range(0, 9) == 0) begin
        mem_ack = 1'b1; mem_rdata = $urandom;
      end
    end
  endtask

  typedef struct {
    bit d; bit we; logic [31:0] addr; logic [31:0] wdata; int lat;
    bit exp_we; logic [31:0] exp_addr; logic [31:0] exp_wdata;
    logic [31:0] exp_if; logic [31:0] exp_dm;
  } row_t;

  task automatic run_row(input row_t r);
    int t, n0;
    logic dn;
    n0 = acc_q.size();
    lat = r.lat;
    if (r.d) begin dm_req = 1; dm_we = r.we; dm_addr = r.addr; dm_wdata = r.wdata; end
    else     begin if_req = 1; if_addr = r.addr; end
    t = 0; dn = 0;
    while (!dn && t < 30) begin
      tick(); t++;
      dn = r.d ? dm_done : if_done;
    end
    dm_req = 0; if_req = 0;
    chk("row_done",        dn, 1);
    chk("row_latency",     t, r.lat + 1);
    chk("row_acc_count",   acc_q.size() - n0, 1);
    if (acc_q.size() > n0) begin
      chk("row_mem_we",   acc_q[n0].we,   r.exp_we);
      chk("row_mem_addr", acc_q[n0].addr, r.exp_addr);
      if (r.exp_we) chk("row_mem_wdata", acc_q[n0].wdata, r.exp_wdata);
    end
    chk("row_if_rdata", if_rdata, r.exp_if);
    chk("row_dm_rdata", dm_rdata, r.exp_dm);
    tick();
    chk("row_done_width", {if_done, dm_done}, 2'b00);
    tick();
  endtask

  initial begin
    row_t        rows[6];
    logic [31:0] exp4[$];
    int          n0, t, nd, nd_target, dd, idn;

    rows[0] = '{0, 0, 32'h10,  32'h0,        2, 0, 32'h10,  32'h0,        32'hCAFE0010, 32'h0};
    rows[1] = '{1, 0, 32'h200, 32'h0,        1, 0, 32'h200, 32'h0,        32'hCAFE0010, 32'h12345678};
    rows[2] = '{0, 0, 32'h300, 32'h0,        3, 0, 32'h300, 32'h0,        32'h0BADF00D, 32'h12345678};
    rows[3] = '{1, 1, 32'h300, 32'h55AA55AA, 1, 1, 32'h300, 32'h55AA55AA, 32'h0BADF00D, 32'h12345678};
    rows[4] = '{1, 0, 32'h300, 32'h0,        2, 0, 32'h300, 32'h0,        32'h0BADF00D, 32'h55AA55AA};
    rows[5] = '{0, 0, 32'h200, 32'h0,        1, 0, 32'h200, 32'h0,        32'h12345678, 32'h55AA55AA};
    mem[32'h10]  = 32'hCAFE0010;
    mem[32'h200] = 32'h12345678;
    mem[32'h300] = 32'h0BADF00D;

    rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    repeat (3) tick();
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_if_rdata",  if_rdata,  0);
    chk("rst_dm_rdata",  dm_rdata,  0);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Simultaneous requests: the store must go first, then the fetch.
    n0 = acc_q.size(); lat = 1; dd = 0; idn = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h40;
    for (t = 0; t < 40 && (dm_req || if_req); t++) begin
      tick();
      if (dm_done) begin dd++; dm_req = 0; dm_we = 0; end
      if (if_done) begin idn++; if_req = 0; end
    end
    chk("both_dm_done", dd, 1);
    chk("both_if_done", idn, 1);
    chk("both_dm_rdata_kept", dm_rdata, 32'h55AA55AA);
    chk("both_acc_count", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2) begin
      chk("both_first_we",    acc_q[n0].we,      1);
      chk("both_first_addr",  acc_q[n0].addr,    32'h100);
      chk("both_first_wdata", acc_q[n0].wdata,   32'hDEADBEEF);
      chk("both_second_addr", acc_q[n0+1].addr,  32'h40);
      chk("both_second_we",   acc_q[n0+1].we,    0);
    end
    repeat (2) tick();

    // Continuous data traffic with a waiting fetch.
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp4 = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h40, 32'h80};
    nd_target = 5;
`else
    exp4 = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h80, 32'h40};
    nd_target = 6;
`endif
    n0 = acc_q.size(); lat = 1; nd = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80; if_req = 1; if_addr = 32'h40;
    for (t = 0; t < 200 && (dm_req || if_req); t++) begin
      tick();
      if (dm_done) begin nd++; if (nd >= nd_target) dm_req = 0; end
      if (if_done) if_req = 0;
    end
    chk("streak_acc_count", acc_q.size() - n0, exp4.size());
    foreach (exp4[i])
      if (n0 + i < acc_q.size()) chk("streak_order", acc_q[n0+i].addr, exp4[i]);
    repeat (2) tick();

    // Data request withdrawn mid-access still completes exactly once.
    n0 = acc_q.size(); lat = 3; dd = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    for (t = 0; t < 10 && !mem_req; t++) tick();
    chk("drop_granted", mem_req, 1);
    dm_req = 0;
    repeat (10) begin tick(); if (dm_done) dd++; end
    chk("drop_done_count", dd, 1);
    chk("drop_acc_count",  acc_q.size() - n0, 1);
    chk("drop_dm_rdata",   dm_rdata, 32'h12345678);

    // Asynchronous reset mid-access, then a stray ack while idle.
    auto_ack = 0; dd = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    for (t = 0; t < 10 && !mem_req; t++) tick();
    chk("rstmid_granted", mem_req, 1);
    rst_n = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_busy",    busy,    0);
    dm_req = 0;
    tick();
    rst_n = 1;
    tick();
    pulse_ack = 1;
    repeat (4) begin tick(); if (dm_done || if_done || mem_req) dd++; end
    chk("late_ack_ignored", dd, 0);
    chk("late_ack_dm_rdata", dm_rdata, 0);
    auto_ack = 1;

    // Randomized traffic against the reference model.
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (if_done) begin
        if ($urandom_range(0, 1) == 0) if_req = 0; else if_addr = $urandom_range(0, 15) << 2;
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom_range(0, 15) << 2; end
      end else begin
        if ($urandom_range(0, 29) == 0) if_req = 0;
        else if ($urandom_range(0, 9) == 0) if_addr = $urandom_range(0, 15) << 2;
      end
      if (dm_done || (!dm_req && $urandom_range(0, 2) == 0)) begin
        dm_req   = (dm_done && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        dm_we    = $urandom_range(0, 1);
        dm_addr  = $urandom_range(0, 15) << 2;
        dm_wdata = $urandom;
      end else if (dm_req && $urandom_range(0, 29) == 0) begin
        dm_req = 0;
      end
    end
    rnd_mode = 0; if_req = 0; dm_req = 0;
    repeat (8) tick();
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
